// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one single-ported memory among N_CH request channels
//               using fixed-priority or round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int RR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          wr,
    input  logic [N_CH*ADDR_W-1:0]   addr,
    input  logic [N_CH*DATA_W-1:0]   wdata,
    output logic [N_CH-1:0]          busy,
    output logic [N_CH-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     mem_en,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] C_LAST_CH = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [N_CH-1:0]     done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [IDX_W-1:0]    w_winner;
    logic                w_found;
    int                  w_cand;

    // Round-robin search starts one past the previous grant and wraps once.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_cand   = 0;
        for (int k = 0; k < N_CH; k++) begin
            if (RR_MODE != 0) begin
                w_cand = int'(last_grant_q) + 1 + k;
                if (w_cand >= N_CH) begin
                    w_cand = w_cand - N_CH;
                end
            end else begin
                w_cand = k;
            end
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = IDX_W'(w_cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_en_d     = mem_en_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = '0;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d      = ST_ISSUE;
                    grant_d      = w_winner;
                    last_grant_d = w_winner;
                    mem_en_d     = 1'b1;
                    mem_wr_d     = wr[w_winner];
                    mem_addr_d   = addr[int'(w_winner)*ADDR_W +: ADDR_W];
                    mem_wdata_d  = wdata[int'(w_winner)*DATA_W +: DATA_W];
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    state_d  = ST_RESP;
                    mem_en_d = 1'b0;
                    if (!mem_wr_q) begin
                        rdata_d = mem_rdata;
                    end
                    for (int i = 0; i < N_CH; i++) begin
                        done_d[i] = (grant_q == IDX_W'(i));
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= C_LAST_CH;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
        end
    end

    assign busy      = req & ~done_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : checks a 2-channel fixed-priority and a 4-channel
//                  round-robin instance of mem_arbiter.
// Revision       : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] d0;
        logic [15:0] d1;
        int          lat;
        int          mid;       // 1: drop req in ISSUE, 2: change addr0 in ISSUE
        int          exp_ch;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          ch;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [1:0]  fx_req = '0, fx_wr = '0, fx_busy, fx_done;
    logic [31:0] fx_addr = '0, fx_wdata = '0;
    logic [15:0] fx_rdata, fx_mem_addr, fx_mem_wdata, fx_mem_rdata = '0;
    logic        fx_mem_en, fx_mem_wr, fx_mem_ack = 1'b0;

    logic [3:0]  rr_req = '0, rr_wr = '0, rr_busy, rr_done;
    logic [63:0] rr_addr = '0, rr_wdata = '0;
    logic [15:0] rr_rdata, rr_mem_addr, rr_mem_wdata, rr_mem_rdata = '0;
    logic        rr_mem_en, rr_mem_wr, rr_mem_ack = 1'b0;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          in_resp  = 1'b0;
    exp_t        sb[$];
    vec_t        vecs[7];
    logic [15:0] mem_model [logic [15:0]];

    always #5 clk = ~clk;

    mem_arbiter #(.N_CH(2), .ADDR_W(16), .DATA_W(16), .RR_MODE(0)) dut_fx (
        .clk(clk), .rst(rst), .req(fx_req), .wr(fx_wr), .addr(fx_addr),
        .wdata(fx_wdata), .busy(fx_busy), .done(fx_done), .rdata(fx_rdata),
        .mem_en(fx_mem_en), .mem_wr(fx_mem_wr), .mem_addr(fx_mem_addr),
        .mem_wdata(fx_mem_wdata), .mem_rdata(fx_mem_rdata), .mem_ack(fx_mem_ack)
    );

    mem_arbiter #(.N_CH(4), .ADDR_W(16), .DATA_W(16), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .req(rr_req), .wr(rr_wr), .addr(rr_addr),
        .wdata(rr_wdata), .busy(rr_busy), .done(rr_done), .rdata(rr_rdata),
        .mem_en(rr_mem_en), .mem_wr(rr_mem_wr), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata), .mem_ack(rr_mem_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full fixed-priority transaction driven from IDLE or from a done cycle.
    task automatic apply_fx(input vec_t v);
        int          n;
        exp_t        e;
        logic [15:0] ea, ed;
        logic        ew;
        logic [1:0]  exp_done;
        ea = (v.exp_ch == 1) ? v.a1 : v.a0;
        ed = (v.exp_ch == 1) ? v.d1 : v.d0;
        ew = v.wr[v.exp_ch];
        fx_req   = v.req;
        fx_wr    = v.wr;
        fx_addr  = {v.a1, v.a0};
        fx_wdata = {v.d1, v.d0};
        sb.push_back('{ch: v.exp_ch, rdata: v.exp_rdata});
        tick();
        n = 1;
        if (in_resp) check("done_pulse_width", {30'd0, fx_done}, 32'd0);
        while (!fx_mem_en && n < 4) begin
            tick();
            n++;
        end
        check("grant_latency", n, in_resp ? 32'd2 : 32'd1);
        for (int i = 1; i <= v.lat; i++) begin
            check("mem_en_issue", {31'd0, fx_mem_en}, 32'd1);
            check("mem_addr", {16'd0, fx_mem_addr}, {16'd0, ea});
            check("mem_wr", {31'd0, fx_mem_wr}, {31'd0, ew});
            if (ew) check("mem_wdata", {16'd0, fx_mem_wdata}, {16'd0, ed});
            check("done_in_issue", {30'd0, fx_done}, 32'd0);
            if (i == 1 && v.mid == 1) fx_req = 2'b00;
            if (i == 1 && v.mid == 2) fx_addr[15:0] = ~v.a0;
            if (i == v.lat) begin
                fx_mem_ack   = 1'b1;
                fx_mem_rdata = mem_model[fx_mem_addr];
                if (fx_mem_wr) mem_model[fx_mem_addr] = fx_mem_wdata;
            end
            tick();
            fx_mem_ack = 1'b0;
        end
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            exp_done = 2'b01 << e.ch;
            check("done", {30'd0, fx_done}, {30'd0, exp_done});
            check("rdata", {16'd0, fx_rdata}, {16'd0, e.rdata});
            check("mem_en_resp", {31'd0, fx_mem_en}, 32'd0);
            check("busy", {30'd0, fx_busy}, {30'd0, fx_req & ~exp_done});
        end
        in_resp = 1'b1;
    endtask

    // Round-robin transaction: wait for the grant, ack at once, compare on done.
    task automatic rr_txn(input logic [15:0] rd);
        int          n;
        exp_t        e;
        logic [15:0] seen_addr;
        n = 0;
        while (!rr_mem_en && n < 8) begin
            tick();
            n++;
        end
        if (!rr_mem_en) begin
            check("rr_grant_timeout", 32'd0, 32'd1);
            return;
        end
        seen_addr    = rr_mem_addr;
        rr_mem_ack   = 1'b1;
        rr_mem_rdata = rd;
        tick();
        rr_mem_ack = 1'b0;
        if (sb.size() == 0) begin
            check("rr_scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("rr_done", {28'd0, rr_done}, 32'd1 << e.ch);
            check("rr_mem_addr", {16'd0, seen_addr}, 32'h1000 + e.ch);
            check("rr_rdata", {16'd0, rr_rdata}, {16'd0, rd});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{req:2'b01, wr:2'b00, a0:16'h0010, a1:16'h0000, d0:16'h0, d1:16'h0, lat:3, mid:0, exp_ch:0, exp_rdata:16'hBEEF};
        vecs[1] = '{req:2'b11, wr:2'b00, a0:16'h0100, a1:16'h0200, d0:16'h0, d1:16'h0, lat:1, mid:0, exp_ch:0, exp_rdata:16'h1111};
        vecs[2] = '{req:2'b11, wr:2'b00, a0:16'h0110, a1:16'h0200, d0:16'h0, d1:16'h0, lat:2, mid:0, exp_ch:0, exp_rdata:16'h2222};
        vecs[3] = '{req:2'b10, wr:2'b10, a0:16'h0000, a1:16'h0040, d0:16'h0, d1:16'h1234, lat:1, mid:0, exp_ch:1, exp_rdata:16'h2222};
        vecs[4] = '{req:2'b01, wr:2'b00, a0:16'h0040, a1:16'h0000, d0:16'h0, d1:16'h0, lat:2, mid:0, exp_ch:0, exp_rdata:16'h1234};
        vecs[5] = '{req:2'b01, wr:2'b00, a0:16'h0300, a1:16'h0000, d0:16'h0, d1:16'h0, lat:2, mid:1, exp_ch:0, exp_rdata:16'h3333};
        vecs[6] = '{req:2'b01, wr:2'b00, a0:16'h0400, a1:16'h0000, d0:16'h0, d1:16'h0, lat:3, mid:2, exp_ch:0, exp_rdata:16'h4444};
        mem_model[16'h0010] = 16'hBEEF;
        mem_model[16'h0100] = 16'h1111;
        mem_model[16'h0110] = 16'h2222;
        mem_model[16'h0200] = 16'h5A5A;
        mem_model[16'h0040] = 16'hDEAD;
        mem_model[16'h0300] = 16'h3333;
        mem_model[16'h0400] = 16'h4444;
        mem_model[16'hFBFF] = 16'hEEEE;

        rst = 1'b1;
        tick();
        tick();
        check("reset_mem_en", {31'd0, fx_mem_en}, 32'd0);
        check("reset_mem_wr", {31'd0, fx_mem_wr}, 32'd0);
        check("reset_mem_addr", {16'd0, fx_mem_addr}, 32'd0);
        check("reset_mem_wdata", {16'd0, fx_mem_wdata}, 32'd0);
        check("reset_done", {30'd0, fx_done}, 32'd0);
        check("reset_rdata", {16'd0, fx_rdata}, 32'd0);
        check("reset_busy", {30'd0, fx_busy}, 32'd0);
        check("reset_rr_mem_en", {31'd0, rr_mem_en}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            apply_fx(vecs[i]);
        end

        // Reset while a transaction is in ISSUE, then a spurious ack in IDLE.
        fx_req = 2'b00;
        tick();
        fx_req  = 2'b01;
        fx_addr = {16'h0000, 16'h0500};
        tick();
        check("rst_issue_mem_en", {31'd0, fx_mem_en}, 32'd1);
        tick();
        rst    = 1'b1;
        fx_req = 2'b00;
        tick();
        rst = 1'b0;
        check("rst_abort_mem_en", {31'd0, fx_mem_en}, 32'd0);
        check("rst_abort_done", {30'd0, fx_done}, 32'd0);
        fx_mem_ack   = 1'b1;
        fx_mem_rdata = 16'hABCD;
        tick();
        fx_mem_ack = 1'b0;
        check("spurious_ack_done", {30'd0, fx_done}, 32'd0);
        check("spurious_ack_rdata", {16'd0, fx_rdata}, 32'd0);
        check("spurious_ack_mem_en", {31'd0, fx_mem_en}, 32'd0);
        tick();
        check("spurious_ack_done_later", {30'd0, fx_done}, 32'd0);
        in_resp = 1'b0;
        apply_fx(vecs[0]);
        fx_req = 2'b00;

        // Round-robin: all four channels requesting continuously.
        rr_addr = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr_req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{ch: k % 4, rdata: 16'h00A0 + 16'(k)});
        end
        for (int k = 0; k < 5; k++) begin
            rr_txn(16'h00A0 + 16'(k));
        end

        rr_req = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_reset_mem_en", {31'd0, rr_mem_en}, 32'd0);
        rr_req = 4'b1000;
        sb.push_back('{ch: 3, rdata: 16'h0C03});
        rr_txn(16'h0C03);
        rr_req = 4'b1001;
        sb.push_back('{ch: 0, rdata: 16'h0C00});
        rr_txn(16'h0C00);
        rr_req = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised arbiter that shares one single-ported main-memory interface among N_CH requesting channels (instruction fetch, data access, and future DMA/debug masters). Each channel presents a level request with address, write flag and write data. The arbiter grants one channel at a time by fixed priority or round-robin, holds the memory transaction until the memory acknowledges it, and returns read data with a one-cycle done pulse. Per-channel busy outputs feed the hazard unit as stall sources, generalising the fixed two-port i/d fsm_busy scheme.

## Interface
Parameters:
- N_CH, 2: number of requesting channels, 1..8; channel 0 is the instruction port by convention.
- ADDR_W, 16: address width.
- DATA_W, 16: data width.
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_CH  per-channel request level; held until the channel's done pulse.
- wr  in  N_CH  per-channel write flag (1 = write, 0 = read).
- addr  in  N_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_CH*DATA_W  packed write data, same packing.
- busy  out  N_CH  busy[i] = req[i] & ~done[i]; combinational stall source.
- done  out  N_CH  one-hot, one-cycle completion pulse.
- rdata  out  DATA_W  read data, valid in the done cycle; broadcast to all channels.
- mem_en  out  1  memory transaction active.
- mem_wr  out  1  write transaction.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion; sampled only in ISSUE.

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if req != 0, select winner g, latch wr[g], addr[g], wdata[g] and g into registers, go to ISSUE. If req == 0, stay in IDLE.
- Fixed mode: g = lowest set index of req.
- RR mode: search starts at (last_grant+1) mod N_CH and wraps. last_grant updates to g on every grant.
- ISSUE: mem_en=1 and mem_wr/mem_addr/mem_wdata are driven from the latched registers, held stable. req/addr changes are ignored. On mem_ack=1: capture mem_rdata into rdata (reads only; writes leave rdata unchanged), go to RESP.
- RESP: done[g]=1 for exactly this cycle, mem_en=0, no arbitration. Always go to IDLE.
- Requester contract: drop req, or present a new transaction, on the edge after sampling done. A req still high in the next IDLE is treated as a new request.
- A channel that drops req during ISSUE still completes; done[g] still pulses.
- mem_ack outside ISSUE is ignored.
- N_CH=1 degenerates to a pass-through FSM; RR pointer is unused.

## Timing
- Reset values: state=IDLE, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, done=0, rdata=0, last_grant=N_CH-1 (channel 0 wins the first RR arbitration).
- Reset mid-transaction aborts: mem_en drops on the next cycle and no done is issued.
- Request sampled in IDLE at cycle t gives mem_en=1 from cycle t+1.
- mem_ack at cycle t+k (k>=1) gives done/rdata at cycle t+k+1 and IDLE at t+k+2.
- Minimum transaction is 3 cycles (ack in the first ISSUE cycle). Back-to-back transactions are spaced by 1 + ack latency + 1 cycles.
- mem_en, mem_wr, mem_addr, mem_wdata, done and rdata are all registered. busy is the only combinational output.
- Simultaneous requests resolve in the same IDLE cycle with no wasted cycle. Losers keep busy=1 until their own done.

## Test plan
- Single read, N_CH=2: req=01, addr0=0x0010; memory model acks 3 cycles after mem_en with 0xBEEF. Required: mem_en high for 3 cycles, mem_addr=0x0010, done=01 one cycle after ack with rdata=0xBEEF, busy[0] low in the done cycle.
- Fixed-priority contention, RR_MODE=0: req=11 held continuously, each channel re-requesting after its done. Required: channel 0 granted every time and channel 1 starves (busy[1] stays 1).
- Round-robin, RR_MODE=1, N_CH=4: req=1111 continuously. Required: grant order 0,1,2,3,0. After reset, req=1000 then req=1001 gives grants 3 then 0.
- Write then read-back: ch1 write 0x1234 to 0x0040, then ch0 read 0x0040. Required: mem_wr=1 and mem_wdata=0x1234 during the write; rdata unchanged at the write's done; the read returns 0x1234.
- Mid-transaction events: ch0 drops req during ISSUE, and separately addr0 changes during ISSUE. Required: mem_addr stays at the latched value and done[0] still pulses.
- Reset in ISSUE. Required: mem_en=0 and state IDLE the next cycle, no done pulse, a subsequent request is served normally, and a spurious mem_ack in IDLE is ignored.
